auth_mem_sequencer: RTL and testbench

Sequences every access to the credential SRAM (password, admin flag, lock flag and try-count per user slot) for the keypad management FSM. It accepts one request at a time through a valid/busy handshake: verify, add, remove, change password or unlock. It performs read, evaluate and conditional write-back, then returns a one-cycle done pulse with a result code. It is the only master of the SRAM control lines.

---
 rtl/auth_pkg.sv | 43 ++++
 rtl/auth_decide.sv | 132 +++++++++++++
 rtl/auth_mem_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_auth_mem_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared definitions for the credential SRAM sequencer.
// Provides the default widths, op codes, result codes, the empty-slot
// password marker and the sequencer state encoding.
package auth_pkg;

    localparam int unsigned ADDR_W_DEF    = 4;
    localparam int unsigned PASS_W_DEF    = 16;
    localparam int unsigned CNT_W_DEF     = 2;
    localparam int unsigned MAX_TRIES_DEF = 3;
    localparam int unsigned OP_W          = 3;
    localparam int unsigned RES_W         = 3;

    // A stored password of all ones marks an unused slot
    localparam logic [PASS_W_DEF-1:0] PASS_EMPTY = {PASS_W_DEF{1'b1}};

    typedef enum logic [OP_W-1:0] {
        OP_VERIFY  = 3'd0,
        OP_ADD     = 3'd1,
        OP_REMOVE  = 3'd2,
        OP_CHGPASS = 3'd3,
        OP_UNLOCK  = 3'd4
    } op_e;

    typedef enum logic [RES_W-1:0] {
        RES_OK         = 3'd0,
        RES_BAD_PASS   = 3'd1,
        RES_LOCKED     = 3'd2,
        RES_LOCKED_NOW = 3'd3,
        RES_DENIED     = 3'd4,
        RES_EXISTS     = 3'd5,
        RES_EMPTY      = 3'd6,
        RES_BAD_OP     = 3'd7
    } res_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EVAL = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/auth_decide.sv
// Combinational decision for one credential request.
// Inputs : latched request (op, req_pass, req_admin, sess_admin) and the
//          stored slot fields (st_pass, st_admin, st_lock, st_count).
// Outputs: result code, admin flag to report, per-field write enables and
//          write data for the write-back cycle.
module auth_decide
    import auth_pkg::*;
#(
    parameter int unsigned PASS_W    = PASS_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic [OP_W-1:0]   op,
    input  logic [PASS_W-1:0] req_pass,
    input  logic              req_admin,
    input  logic              sess_admin,
    input  logic [PASS_W-1:0] st_pass,
    input  logic              st_admin,
    input  logic              st_lock,
    input  logic [CNT_W-1:0]  st_count,
    output res_e              result_c,
    output logic              is_admin_c,
    output logic              we_pass_c,
    output logic              we_admin_c,
    output logic              we_lock_c,
    output logic              we_count_c,
    output logic [PASS_W-1:0] wr_pass_c,
    output logic              wr_admin_c,
    output logic              wr_lock_c,
    output logic [CNT_W-1:0]  wr_count_c
);

    localparam logic [PASS_W-1:0] EMPTY_PASS = {PASS_W{1'b1}};
    localparam logic [CNT_W:0]    TRIES_LIM  = (CNT_W+1)'(MAX_TRIES);

    logic             slot_empty;
    logic             pass_match;
    logic [CNT_W:0]   tries;
    logic [CNT_W-1:0] tries_sat;

    // Decision table; anything not explicitly granted writes nothing
    always_comb begin
        slot_empty = (st_pass == EMPTY_PASS);
        pass_match = (st_pass == req_pass);
        tries      = {1'b0, st_count} + (CNT_W+1)'(1);
        // Counter saturates instead of wrapping back to zero
        tries_sat  = tries[CNT_W] ? {CNT_W{1'b1}} : tries[CNT_W-1:0];

        result_c   = RES_BAD_OP;
        is_admin_c = 1'b0;
        we_pass_c  = 1'b0;
        we_admin_c = 1'b0;
        we_lock_c  = 1'b0;
        we_count_c = 1'b0;
        wr_pass_c  = req_pass;
        wr_admin_c = 1'b0;
        wr_lock_c  = 1'b0;
        wr_count_c = '0;

        case (op)
            OP_VERIFY: begin
                if (slot_empty) begin
                    result_c = RES_EMPTY;
                end else if (st_lock) begin
                    result_c = RES_LOCKED;
                end else if (pass_match) begin
                    result_c   = RES_OK;
                    is_admin_c = st_admin;
                    we_count_c = 1'b1;
                end else begin
                    we_count_c = 1'b1;
                    wr_count_c = tries_sat;
                    if (tries >= TRIES_LIM) begin
                        result_c  = RES_LOCKED_NOW;
                        we_lock_c = 1'b1;
                        wr_lock_c = 1'b1;
                    end else begin
                        result_c = RES_BAD_PASS;
                    end
                end
            end
            OP_ADD: begin
                if (!sess_admin) begin
                    result_c = RES_DENIED;
                end else if (!slot_empty) begin
                    result_c = RES_EXISTS;
                end else begin
                    result_c   = RES_OK;
                    {we_pass_c, we_admin_c, we_lock_c, we_count_c} = 4'b1111;
                    wr_admin_c = req_admin;
                end
            end
            OP_REMOVE: begin
                if (!sess_admin) begin
                    result_c = RES_DENIED;
                end else if (slot_empty) begin
                    result_c = RES_EMPTY;
                end else begin
                    result_c  = RES_OK;
                    {we_pass_c, we_admin_c, we_lock_c, we_count_c} = 4'b1111;
                    wr_pass_c = EMPTY_PASS;
                end
            end
            OP_CHGPASS: begin
                // Writing the empty marker would silently delete the slot
                if (req_pass == EMPTY_PASS) begin
                    result_c = RES_BAD_OP;
                end else if (slot_empty) begin
                    result_c = RES_EMPTY;
                end else if (st_lock && !sess_admin) begin
                    result_c = RES_LOCKED;
                end else begin
                    result_c  = RES_OK;
                    we_pass_c = 1'b1;
                end
            end
            OP_UNLOCK: begin
                if (!sess_admin) begin
                    result_c = RES_DENIED;
                end else if (slot_empty) begin
                    result_c = RES_EMPTY;
                end else begin
                    result_c   = RES_OK;
                    we_lock_c  = 1'b1;
                    we_count_c = 1'b1;
                end
            end
            default: result_c = RES_BAD_OP;
        endcase
    end

endmodule

// File: rtl/auth_mem_sequencer.sv
// Credential SRAM sequencer: accepts one request at a time, reads the slot,
// decides, optionally writes back, then pulses done with a result code.
// Ports: clk/RST; request handshake req_valid/req_op/req_addr/req_pass/
//        req_admin/sess_admin; status busy/done/result/is_admin;
//        SRAM master mem_cs/mem_*_rw/mem_addr/mem_*_in, read data mem_*_out.
module auth_mem_sequencer
    import auth_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned PASS_W    = PASS_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              req_valid,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [PASS_W-1:0] req_pass,
    input  logic              req_admin,
    input  logic              sess_admin,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic              is_admin,
    output logic              mem_cs,
    output logic              mem_pass_rw,
    output logic              mem_admin_rw,
    output logic              mem_lock_rw,
    output logic              mem_count_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PASS_W-1:0] mem_pass_in,
    output logic [CNT_W-1:0]  mem_count_in,
    output logic              mem_admin_in,
    output logic              mem_lock_in,
    input  logic [PASS_W-1:0] mem_pass_out,
    input  logic [CNT_W-1:0]  mem_count_out,
    input  logic              mem_admin_out,
    input  logic              mem_lock_out
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              admin_q, admin_d;
    logic              sess_q, sess_d;
    res_e              res_q, res_d;
    logic              pend_admin_q, pend_admin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              is_admin_q, is_admin_d;
    logic              cs_q, cs_d;
    logic [3:0]        rw_q, rw_d;       // {pass, admin, lock, count}
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [PASS_W-1:0] wpass_q, wpass_d;
    logic [CNT_W-1:0]  wcount_q, wcount_d;
    logic              wadmin_q, wadmin_d;
    logic              wlock_q, wlock_d;

    res_e              dec_result;
    logic              dec_is_admin;
    logic [3:0]        dec_we;
    logic [PASS_W-1:0] dec_pass;
    logic              dec_admin;
    logic              dec_lock;
    logic [CNT_W-1:0]  dec_count;

    // Decision works on read data while it is valid during EVAL
    auth_decide #(
        .PASS_W    (PASS_W),
        .CNT_W     (CNT_W),
        .MAX_TRIES (MAX_TRIES)
    ) u_decide (
        .op         (op_q),
        .req_pass   (pass_q),
        .req_admin  (admin_q),
        .sess_admin (sess_q),
        .st_pass    (mem_pass_out),
        .st_admin   (mem_admin_out),
        .st_lock    (mem_lock_out),
        .st_count   (mem_count_out),
        .result_c   (dec_result),
        .is_admin_c (dec_is_admin),
        .we_pass_c  (dec_we[3]),
        .we_admin_c (dec_we[2]),
        .we_lock_c  (dec_we[1]),
        .we_count_c (dec_we[0]),
        .wr_pass_c  (dec_pass),
        .wr_admin_c (dec_admin),
        .wr_lock_c  (dec_lock),
        .wr_count_c (dec_count)
    );

    // Next-state and registered-output logic; SRAM controls idle at zero
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        pass_d       = pass_q;
        admin_d      = admin_q;
        sess_d       = sess_q;
        res_d        = res_q;
        pend_admin_d = pend_admin_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        result_d     = result_q;
        is_admin_d   = 1'b0;
        cs_d         = 1'b0;
        rw_d         = 4'b0000;
        maddr_d      = '0;
        wpass_d      = '0;
        wcount_d     = '0;
        wadmin_d     = 1'b0;
        wlock_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RD;
                    op_d    = req_op;
                    addr_d  = req_addr;
                    pass_d  = req_pass;
                    admin_d = req_admin;
                    sess_d  = sess_admin;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    maddr_d = req_addr;
                end
            end
            ST_RD: begin
                state_d = ST_EVAL;
                busy_d  = 1'b1;
            end
            ST_EVAL: begin
                state_d      = ST_WR;
                busy_d       = 1'b1;
                res_d        = dec_result;
                pend_admin_d = dec_is_admin;
                if (dec_we != 4'b0000) begin
                    cs_d     = 1'b1;
                    rw_d     = dec_we;
                    maddr_d  = addr_q;
                    wpass_d  = dec_pass;
                    wadmin_d = dec_admin;
                    wlock_d  = dec_lock;
                    wcount_d = dec_count;
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
                busy_d  = 1'b1;
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                result_d   = RES_W'(res_q);
                is_admin_d = pend_admin_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears every output immediately
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            pass_q       <= '0;
            admin_q      <= 1'b0;
            sess_q       <= 1'b0;
            res_q        <= RES_OK;
            pend_admin_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            is_admin_q   <= 1'b0;
            cs_q         <= 1'b0;
            rw_q         <= 4'b0000;
            maddr_q      <= '0;
            wpass_q      <= '0;
            wcount_q     <= '0;
            wadmin_q     <= 1'b0;
            wlock_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            pass_q       <= pass_d;
            admin_q      <= admin_d;
            sess_q       <= sess_d;
            res_q        <= res_d;
            pend_admin_q <= pend_admin_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            is_admin_q   <= is_admin_d;
            cs_q         <= cs_d;
            rw_q         <= rw_d;
            maddr_q      <= maddr_d;
            wpass_q      <= wpass_d;
            wcount_q     <= wcount_d;
            wadmin_q     <= wadmin_d;
            wlock_q      <= wlock_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign is_admin     = is_admin_q;
    assign mem_cs       = cs_q;
    assign mem_pass_rw  = rw_q[3];
    assign mem_admin_rw = rw_q[2];
    assign mem_lock_rw  = rw_q[1];
    assign mem_count_rw = rw_q[0];
    assign mem_addr     = maddr_q;
    assign mem_pass_in  = wpass_q;
    assign mem_count_in = wcount_q;
    assign mem_admin_in = wadmin_q;
    assign mem_lock_in  = wlock_q;

endmodule

// File: tb/tb_auth_mem_sequencer.sv
// Bench for auth_mem_sequencer: SRAM model plus a reference model of the
// credential rules, directed scenarios followed by random requests.
module tb_auth_mem_sequencer;

    localparam int R_OK = 0, R_BAD_PASS = 1, R_LOCKED = 2, R_LOCKED_NOW = 3;
    localparam int R_DENIED = 4, R_EXISTS = 5, R_EMPTY = 6, R_BAD_OP = 7;
    localparam int MAXT = 3;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [3:0]  req_addr = '0;
    logic [15:0] req_pass = '0;
    logic        req_admin = 1'b0;
    logic        sess_admin = 1'b0;
    logic        busy, done, is_admin;
    logic [2:0]  result;
    logic        mem_cs, mem_pass_rw, mem_admin_rw, mem_lock_rw, mem_count_rw;
    logic [3:0]  mem_addr;
    logic [15:0] mem_pass_in;
    logic [1:0]  mem_count_in;
    logic        mem_admin_in, mem_lock_in;
    logic [15:0] mem_pass_out = '0;
    logic [1:0]  mem_count_out = '0;
    logic        mem_admin_out = 1'b0;
    logic        mem_lock_out = 1'b0;

    // SRAM contents as seen by the DUT
    logic [15:0] sram_pass  [16] = '{default: 16'hFFFF};
    logic        sram_admin [16] = '{default: 1'b0};
    logic        sram_lock  [16] = '{default: 1'b0};
    logic [1:0]  sram_count [16] = '{default: 2'd0};
    int          wr_cycles = 0;

    // Expected contents
    logic [15:0] ref_pass  [16] = '{default: 16'hFFFF};
    logic        ref_admin [16] = '{default: 1'b0};
    logic        ref_lock  [16] = '{default: 1'b0};
    int          ref_count [16] = '{default: 0};

    int n_tests = 0;
    int n_fail  = 0;

    auth_mem_sequencer dut (
        .clk           (clk),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_pass      (req_pass),
        .req_admin     (req_admin),
        .sess_admin    (sess_admin),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .is_admin      (is_admin),
        .mem_cs        (mem_cs),
        .mem_pass_rw   (mem_pass_rw),
        .mem_admin_rw  (mem_admin_rw),
        .mem_lock_rw   (mem_lock_rw),
        .mem_count_rw  (mem_count_rw),
        .mem_addr      (mem_addr),
        .mem_pass_in   (mem_pass_in),
        .mem_count_in  (mem_count_in),
        .mem_admin_in  (mem_admin_in),
        .mem_lock_in   (mem_lock_in),
        .mem_pass_out  (mem_pass_out),
        .mem_count_out (mem_count_out),
        .mem_admin_out (mem_admin_out),
        .mem_lock_out  (mem_lock_out)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_pass_rw | mem_admin_rw | mem_lock_rw | mem_count_rw) begin
                wr_cycles = wr_cycles + 1;
                if (mem_pass_rw)  sram_pass[mem_addr]  <= mem_pass_in;
                if (mem_admin_rw) sram_admin[mem_addr] <= mem_admin_in;
                if (mem_lock_rw)  sram_lock[mem_addr]  <= mem_lock_in;
                if (mem_count_rw) sram_count[mem_addr] <= mem_count_in;
            end else begin
                mem_pass_out  <= sram_pass[mem_addr];
                mem_admin_out <= sram_admin[mem_addr];
                mem_lock_out  <= sram_lock[mem_addr];
                mem_count_out <= sram_count[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Credential rules applied to the expected store
    task automatic model(input int op, input int a, input logic [15:0] pw, input logic adm,
                         input logic sess, output int res, output int e_adm, output int wrote);
        logic empty;
        int   tries;
        empty = (ref_pass[a] == 16'hFFFF);
        e_adm = 0;
        wrote = 0;
        res   = R_BAD_OP;
        if (op == 0) begin
            if (empty) res = R_EMPTY;
            else if (ref_lock[a]) res = R_LOCKED;
            else if (pw == ref_pass[a]) begin
                res = R_OK; e_adm = int'(ref_admin[a]); ref_count[a] = 0; wrote = 1;
            end else begin
                tries = ref_count[a] + 1;
                ref_count[a] = (tries > 3) ? 3 : tries;
                wrote = 1;
                if (tries >= MAXT) begin res = R_LOCKED_NOW; ref_lock[a] = 1'b1; end
                else res = R_BAD_PASS;
            end
        end else if (op == 1 || op == 2 || op == 4) begin
            if (!sess) res = R_DENIED;
            else if (op == 1 && !empty) res = R_EXISTS;
            else if (op != 1 && empty) res = R_EMPTY;
            else begin
                res = R_OK; wrote = 1;
                ref_lock[a] = 1'b0; ref_count[a] = 0;
                if (op == 1) begin ref_pass[a] = pw; ref_admin[a] = adm; end
                if (op == 2) begin ref_pass[a] = 16'hFFFF; ref_admin[a] = 1'b0; end
            end
        end else if (op == 3) begin
            if (pw == 16'hFFFF) res = R_BAD_OP;
            else if (empty) res = R_EMPTY;
            else if (ref_lock[a] && !sess) res = R_LOCKED;
            else begin res = R_OK; wrote = 1; ref_pass[a] = pw; end
        end
    endtask

    task automatic run_txn(input int op, input int a, input logic [15:0] pw,
                           input logic adm, input logic sess);
        int e_res, e_adm, e_wr, wr0;
        model(op, a, pw, adm, sess, e_res, e_adm, e_wr);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'(op); req_addr = 4'(a);
        req_pass = pw; req_admin = adm; sess_admin = sess;
        wr0 = wr_cycles;
        @(posedge clk); #1;
        chk("acc_busy", 32'(busy), 1);
        chk("rd_cs", 32'(mem_cs), 1);
        chk("rd_rw", 32'({mem_pass_rw, mem_admin_rw, mem_lock_rw, mem_count_rw}), 0);
        chk("rd_addr", 32'(mem_addr), 32'(a));
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("eval_cs", 32'(mem_cs), 0);
        chk("eval_done", 32'(done), 0);
        @(posedge clk); #1;
        chk("wr_cs", 32'(mem_cs), 32'(e_wr));
        @(posedge clk); #1;
        chk("dn_state", 32'({busy, done, mem_cs}), 32'b100);
        @(posedge clk); #1;
        chk("done", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("result", 32'(result), 32'(e_res));
        chk("is_admin", 32'(is_admin), 32'(e_adm));
        chk("wr_cycles", 32'(wr_cycles - wr0), 32'(e_wr));
        chk("sram_pass", 32'(sram_pass[a]), 32'(ref_pass[a]));
        chk("sram_admin", 32'(sram_admin[a]), 32'(ref_admin[a]));
        chk("sram_lock", 32'(sram_lock[a]), 32'(ref_lock[a]));
        chk("sram_count", 32'(sram_count[a]), 32'(ref_count[a]));
    endtask

    initial begin
        int dones;
        int pick;
        logic [15:0] pw;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({busy, done, is_admin, mem_cs, mem_pass_rw, mem_admin_rw,
                             mem_lock_rw, mem_count_rw}), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_mem_data", 32'({mem_addr, mem_pass_in, mem_count_in, mem_admin_in, mem_lock_in}), 0);
        @(negedge clk);
        RST = 1'b0;

        // Add, three bad verifies to lockout, then a locked verify
        run_txn(1, 3, 16'h1234, 1'b0, 1'b1);
        run_txn(0, 3, 16'h1111, 1'b0, 1'b0);
        run_txn(0, 3, 16'h1111, 1'b0, 1'b0);
        run_txn(0, 3, 16'h1111, 1'b0, 1'b0);
        chk("lockout_cnt", 32'(sram_count[3]), 3);
        chk("lockout_flag", 32'(sram_lock[3]), 1);
        run_txn(0, 3, 16'h1234, 1'b0, 1'b0);
        // Unlock without and with admin, then good verify
        run_txn(4, 3, 16'h0000, 1'b0, 1'b0);
        run_txn(4, 3, 16'h0000, 1'b0, 1'b1);
        run_txn(0, 3, 16'h1234, 1'b0, 1'b0);
        // Duplicate add, remove, verify on empty
        run_txn(1, 3, 16'h5555, 1'b1, 1'b1);
        run_txn(2, 3, 16'h0000, 1'b0, 1'b1);
        chk("removed_pass", 32'(sram_pass[3]), 32'h0000FFFF);
        run_txn(0, 3, 16'h1234, 1'b0, 1'b0);
        // Admin slot reports is_admin; change password paths
        run_txn(1, 5, 16'h0420, 1'b1, 1'b1);
        run_txn(0, 5, 16'h0420, 1'b0, 1'b0);
        run_txn(3, 5, 16'hFFFF, 1'b0, 1'b1);
        run_txn(3, 5, 16'h9876, 1'b0, 1'b0);
        run_txn(0, 5, 16'h9876, 1'b0, 1'b0);
        // Illegal op
        run_txn(7, 2, 16'h0000, 1'b0, 1'b1);

        // req_valid held high: one done per five-cycle transaction
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd6; req_addr = 4'd2; sess_admin = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        chk("held_dones", 32'(dones), 2);
        chk("held_result", 32'(result), R_BAD_OP);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during the write cycle of a failed verify
        run_txn(1, 6, 16'hABCD, 1'b0, 1'b1);
        run_txn(0, 9, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_addr = 4'd6; req_pass = 16'h0000; sess_admin = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_wr", 32'({mem_cs, mem_count_rw}), 32'b11);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_ctrl", 32'({busy, done, mem_cs, mem_count_rw, mem_lock_rw}), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
        chk("rst_no_write", 32'(sram_count[6]), 0);
        run_txn(0, 6, 16'hABCD, 1'b0, 1'b0);

        // Random requests
        for (int i = 0; i < 80; i++) begin
            pick = int'($urandom_range(0, 3));
            case (pick)
                0: pw = 16'h1234;
                1: pw = 16'h1111;
                2: pw = 16'hFFFF;
                default: pw = 16'($urandom);
            endcase
            run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), pw,
                    1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
